// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared widths, requester ids and FSM encoding for mem_port_arbiter.
package mem_arb_pkg;
  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;
  localparam int REQ_IF = 0;
  localparam int REQ_LD = 1;
  localparam int REQ_ST = 2;
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester handshakes plus the shared RAM port.
interface mem_port_arbiter_if #(
  parameter int AW = mem_arb_pkg::DEF_AW,
  parameter int DW = mem_arb_pkg::DEF_DW
);
  logic          if_req, ld_req, st_req;
  logic [AW-1:0] if_addr, ld_addr, st_addr;
  logic [DW-1:0] st_data;
  logic          if_gnt, ld_gnt, st_gnt;
  logic          if_rvalid, ld_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] Daddress;
  logic [DW-1:0] Dout;
  logic          W;
  logic [DW-1:0] DataIn;
  modport slave (
    input  if_req, ld_req, st_req, if_addr, ld_addr, st_addr, st_data, DataIn,
    output if_gnt, ld_gnt, st_gnt, if_rvalid, ld_rvalid, rdata, Daddress, Dout, W
  );
  modport master (
    output if_req, ld_req, st_req, if_addr, ld_addr, st_addr, st_data, DataIn,
    input  if_gnt, ld_gnt, st_gnt, if_rvalid, ld_rvalid, rdata, Daddress, Dout, W
  );
endinterface

// File: rtl/mem_port_arbiter_prio_sel.sv
// mem_arb_prio_sel: fixed store > load > fetch priority, overridable in favour of fetch.
module mem_arb_prio_sel
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       force_if,
  output logic [2:0] win,
  output logic       valid
);
  logic f;
  assign f           = force_if & req[REQ_IF];
  assign win[REQ_ST] = req[REQ_ST] & ~f;
  assign win[REQ_LD] = req[REQ_LD] & ~req[REQ_ST] & ~f;
  assign win[REQ_IF] = req[REQ_IF] & (f | ~(req[REQ_ST] | req[REQ_LD]));
  assign valid       = |req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch/load/store onto one RAM port.
// Define MEM_PORT_ARBITER_STARVE_EN to force a fetch grant after MAX_WAIT lost arbitrations.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input logic Clock,
  input logic Reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(RD_LAT + 1);
  state_t        state;
  logic [CW-1:0] rd_cnt;
  logic          is_st, is_ld, valid, done, force_if;
  logic [2:0]    win;
  mem_arb_prio_sel u_sel (
    .req      ({bus.st_req, bus.ld_req, bus.if_req}),
    .force_if (force_if),
    .win      (win),
    .valid    (valid)
  );
  assign done = (state == ISSUE && !is_st && RD_LAT == 1) || (state == RD_WAIT && rd_cnt == CW'(1));
`ifdef MEM_PORT_ARBITER_STARVE_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;
  assign force_if = wait_cnt == WW'(MAX_WAIT);
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) wait_cnt <= '0;
    else if (state == IDLE && valid)
      wait_cnt <= win[REQ_IF] ? '0 : (bus.if_req && !force_if) ? wait_cnt + WW'(1) : wait_cnt;
`else
  assign force_if = 1'b0;
`endif
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state         <= IDLE;
      rd_cnt        <= '0;
      is_st         <= 1'b0;
      is_ld         <= 1'b0;
      bus.if_gnt    <= 1'b0;
      bus.ld_gnt    <= 1'b0;
      bus.st_gnt    <= 1'b0;
      bus.W         <= 1'b0;
      bus.if_rvalid <= 1'b0;
      bus.ld_rvalid <= 1'b0;
      bus.Daddress  <= '0;
      bus.Dout      <= '0;
      bus.rdata     <= '0;
    end else begin
      bus.if_gnt    <= 1'b0;
      bus.ld_gnt    <= 1'b0;
      bus.st_gnt    <= 1'b0;
      bus.W         <= 1'b0;
      bus.if_rvalid <= done & ~is_ld;
      bus.ld_rvalid <= done & is_ld;
      if (done) bus.rdata <= bus.DataIn;
      case (state)
        IDLE: if (valid) begin
          state <= ISSUE;
          {bus.st_gnt, bus.ld_gnt, bus.if_gnt} <= win;
          bus.Daddress <= win[REQ_ST] ? bus.st_addr : win[REQ_LD] ? bus.ld_addr : bus.if_addr;
          bus.W  <= win[REQ_ST];
          if (win[REQ_ST]) bus.Dout <= bus.st_data;
          is_st  <= win[REQ_ST];
          is_ld  <= win[REQ_LD];
          rd_cnt <= CW'(RD_LAT);
        end
        ISSUE: begin
          state  <= (is_st || RD_LAT == 1) ? IDLE : RD_WAIT;
          rd_cnt <= rd_cnt - CW'(1);
        end
        RD_WAIT: begin
          state  <= done ? IDLE : RD_WAIT;
          rd_cnt <= rd_cnt - CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks on an RD_LAT=1 and an RD_LAT=3 instance sharing clock and reset.
module tb_mem_port_arbiter;
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  int n = 0;
  int errs = 0;
  logic [15:0] mem [256];
  int g [6];
  int k;
  int exp_g [6];
  always #5 Clock = ~Clock;
  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b3 ();
  mem_port_arbiter #(.RD_LAT(1), .MAX_WAIT(4)) dut1 (.Clock(Clock), .Reset(Reset), .bus(b1.slave));
  mem_port_arbiter #(.RD_LAT(3), .MAX_WAIT(4)) dut3 (.Clock(Clock), .Reset(Reset), .bus(b3.slave));
  assign b1.DataIn = mem[b1.Daddress[7:0]];
  assign b3.DataIn = mem[b3.Daddress[7:0]];
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n++;
    if (o !== e) begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    mem[8'h05] = 16'hBEEF;
    mem[8'h20] = 16'h5555;
    mem[8'h30] = 16'h6666;
    mem[8'h02] = 16'hA5A5;
    {b1.if_req, b1.ld_req, b1.st_req} = 3'b000;
    {b3.if_req, b3.ld_req, b3.st_req} = 3'b000;
    b1.if_addr = '0; b1.ld_addr = '0; b1.st_addr = '0; b1.st_data = '0;
    b3.if_addr = '0; b3.ld_addr = '0; b3.st_addr = '0; b3.st_data = '0;
    tick();
    tick();
    chk("rst_W", b1.W, 1'b0);
    chk("rst_gnt", {b1.st_gnt, b1.ld_gnt, b1.if_gnt}, 3'b000);
    chk("rst_rvalid", {b1.ld_rvalid, b1.if_rvalid}, 2'b00);
    chk("rst_daddr", b1.Daddress, 16'h0000);
    chk("rst_dout", b1.Dout, 16'h0000);
    chk("rst_rdata", b1.rdata, 16'h0000);
    chk("rst_W3", b3.W, 1'b0);
    #2 Reset = 1'b1;
    b1.if_req = 1'b1; b1.if_addr = 16'h0005;
    tick();
    chk("if_gnt_e1", b1.if_gnt, 1'b1);
    chk("if_daddr_e1", b1.Daddress, 16'h0005);
    chk("if_W_e1", b1.W, 1'b0);
    b1.if_req = 1'b0;
    tick();
    chk("if_rvalid_e2", b1.if_rvalid, 1'b1);
    chk("if_rdata_e2", b1.rdata, 16'hBEEF);
    chk("if_gnt_e2", b1.if_gnt, 1'b0);
    chk("if_W_e2", b1.W, 1'b0);
    tick();
    chk("if_rvalid_e3", b1.if_rvalid, 1'b0);
    chk("rdata_hold", b1.rdata, 16'hBEEF);
    b1.st_req = 1'b1; b1.st_addr = 16'h0010; b1.st_data = 16'h1234;
    b1.ld_req = 1'b1; b1.ld_addr = 16'h0020;
    b1.if_req = 1'b1; b1.if_addr = 16'h0030;
    tick();
    chk("all_gnt_e1", {b1.st_gnt, b1.ld_gnt, b1.if_gnt}, 3'b100);
    chk("st_W_e1", b1.W, 1'b1);
    chk("st_daddr", b1.Daddress, 16'h0010);
    chk("st_dout", b1.Dout, 16'h1234);
    b1.st_req = 1'b0;
    tick();
    chk("all_gnt_e2", {b1.st_gnt, b1.ld_gnt, b1.if_gnt}, 3'b000);
    chk("st_W_e2", b1.W, 1'b0);
    tick();
    chk("all_gnt_e3", {b1.st_gnt, b1.ld_gnt, b1.if_gnt}, 3'b010);
    chk("ld_daddr", b1.Daddress, 16'h0020);
    chk("ld_W", b1.W, 1'b0);
    chk("dout_hold", b1.Dout, 16'h1234);
    b1.ld_req = 1'b0;
    tick();
    chk("ld_rvalid", {b1.ld_rvalid, b1.if_rvalid}, 2'b10);
    chk("ld_rdata", b1.rdata, 16'h5555);
    tick();
    chk("all_gnt_e5", {b1.st_gnt, b1.ld_gnt, b1.if_gnt}, 3'b001);
    chk("if2_daddr", b1.Daddress, 16'h0030);
    b1.if_req = 1'b0;
    tick();
    chk("if2_rvalid", {b1.ld_rvalid, b1.if_rvalid}, 2'b01);
    chk("if2_rdata", b1.rdata, 16'h6666);
    b3.ld_req = 1'b1; b3.ld_addr = 16'h0002;
    b3.if_req = 1'b1; b3.if_addr = 16'h0005;
    tick();
    chk("l3_gnt_e1", {b3.st_gnt, b3.ld_gnt, b3.if_gnt}, 3'b010);
    chk("l3_daddr", b3.Daddress, 16'h0002);
    b3.ld_req = 1'b0;
    tick();
    chk("l3_busy_e2", {b3.st_gnt, b3.ld_gnt, b3.if_gnt, b3.ld_rvalid, b3.if_rvalid}, 5'b0);
    tick();
    chk("l3_busy_e3", {b3.st_gnt, b3.ld_gnt, b3.if_gnt, b3.ld_rvalid, b3.if_rvalid}, 5'b0);
    tick();
    chk("l3_rvalid_e4", {b3.ld_rvalid, b3.if_rvalid}, 2'b10);
    chk("l3_rdata", b3.rdata, 16'hA5A5);
    chk("l3_gnt_e4", {b3.st_gnt, b3.ld_gnt, b3.if_gnt}, 3'b000);
    tick();
    chk("l3_ifgnt_e5", {b3.st_gnt, b3.ld_gnt, b3.if_gnt}, 3'b001);
    b3.if_req = 1'b0;
    tick(); tick(); tick();
    chk("l3_if_rvalid", {b3.ld_rvalid, b3.if_rvalid}, 2'b01);
    chk("l3_if_rdata", b3.rdata, 16'hBEEF);
    b1.st_req = 1'b1; b1.st_addr = 16'h0040; b1.st_data = 16'h9999;
    tick();
    chk("rs_W_before", b1.W, 1'b1);
    b1.st_req = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("rs_W_async", b1.W, 1'b0);
    chk("rs_dout_async", b1.Dout, 16'h0000);
    tick();
    #2 Reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rs_quiet", {b1.W, b1.st_gnt, b1.ld_gnt, b1.if_gnt, b1.ld_rvalid, b1.if_rvalid}, 6'b0);
    end
    b1.ld_req = 1'b1; b1.ld_addr = 16'h0007;
    b1.if_req = 1'b1; b1.if_addr = 16'h0008;
    k = 0;
    for (int c = 0; c < 20 && k < 6; c++) begin
      tick();
      if (b1.ld_gnt) begin g[k] = 1; k++; end
      else if (b1.if_gnt) begin g[k] = 0; k++; end
    end
    b1.ld_req = 1'b0; b1.if_req = 1'b0;
`ifdef MEM_PORT_ARBITER_STARVE_EN
    exp_g = '{1, 1, 1, 1, 0, 1};
`else
    exp_g = '{1, 1, 1, 1, 1, 1};
`endif
    chk("sv_grants_seen", k >= 6, 1'b1);
    for (int i = 0; i < k; i++) chk("sv_grant_order", g[i], exp_g[i]);
    tick(); tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
